// File: rtl/v7_filter_ctrl.sv
// Run-control and pulse-event sequencer for the variant-7 shaping filter.
// Flushes/settles the filter, then captures peak amplitude and timestamp per pulse.
module v7_filter_ctrl #(
   parameter int SIZE_FILTER_DATA = 16,
   parameter int TS_WIDTH         = 32,
   parameter int FLUSH_CYCLES     = 2,
   parameter int SETTLE_CYCLES    = 32,
   parameter int DEAD_TIME        = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cfg_en,
   input  logic                        flush_req,
   input  logic [SIZE_FILTER_DATA-1:0] cfg_threshold,
   input  logic [SIZE_FILTER_DATA-1:0] filt_data,
   output logic                        filt_rst_n,
   output logic                        evt_valid,
   input  logic                        evt_ready,
   output logic [SIZE_FILTER_DATA-1:0] evt_peak,
   output logic [TS_WIDTH-1:0]         evt_time,
   output logic [7:0]                  drop_cnt,
   output logic                        busy
);

   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      S_IDLE, S_FLUSH, S_SETTLE, S_ARMED, S_PEAK, S_DEAD
   } state_t;

   state_t                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [TS_WIDTH-1:0]         ts_q, ts_d;
   logic [SIZE_FILTER_DATA-1:0] peak_q, peak_d;
   logic [TS_WIDTH-1:0]         ptime_q, ptime_d;
   logic                        evt_valid_q, evt_valid_d;
   logic [SIZE_FILTER_DATA-1:0] evt_peak_q, evt_peak_d;
   logic [TS_WIDTH-1:0]         evt_time_q, evt_time_d;
   logic [7:0]                  drop_cnt_q, drop_cnt_d;
   logic                        emit;
   logic                        out_free;

   // Handshake: a transfer occurs on any rising edge where evt_valid and evt_ready
   // are both high; evt_valid/evt_peak/evt_time hold until then, and evt_ready
   // is ignored while evt_valid is low.

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      peak_d  = peak_q;
      ptime_d = ptime_q;
      emit    = 1'b0;
      ts_d    = ts_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (cfg_en) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // SETTLE and DEAD hand over one count early so that the first ARMED
         // sample lands exactly N edges after the state was entered.
         S_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 2)) begin
               state_d = S_ARMED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ARMED: begin
            if (filt_data > cfg_threshold) begin
               peak_d  = filt_data;
               ptime_d = ts_q;
               state_d = S_PEAK;
            end
         end
         S_PEAK: begin
            if (filt_data < cfg_threshold) begin
               emit    = 1'b1;
               state_d = S_DEAD;
               cnt_d   = '0;
            end else if (filt_data > peak_q) begin
               peak_d  = filt_data;
               ptime_d = ts_q;
            end
         end
         S_DEAD: begin
            if (cnt_q == CNT_W'(DEAD_TIME - 2)) begin
               state_d = S_ARMED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Aborts override the normal transition and discard any pulse in progress.
      if (!cfg_en) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         emit    = 1'b0;
      end else if (flush_req && state_q != S_IDLE) begin
         state_d = S_FLUSH;
         cnt_d   = '0;
         emit    = 1'b0;
      end
   end

   always_comb begin
      evt_valid_d = evt_valid_q;
      evt_peak_d  = evt_peak_q;
      evt_time_d  = evt_time_q;
      drop_cnt_d  = drop_cnt_q;
      out_free    = !evt_valid_q || evt_ready;

      if (evt_valid_q && evt_ready) evt_valid_d = 1'b0;

      if (emit) begin
         if (out_free) begin
            evt_valid_d = 1'b1;
            evt_peak_d  = peak_q;
            evt_time_d  = ptime_q;
         end else if (drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ts_q        <= '0;
         peak_q      <= '0;
         ptime_q     <= '0;
         evt_valid_q <= 1'b0;
         evt_peak_q  <= '0;
         evt_time_q  <= '0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ts_q        <= ts_d;
         peak_q      <= peak_d;
         ptime_q     <= ptime_d;
         evt_valid_q <= evt_valid_d;
         evt_peak_q  <= evt_peak_d;
         evt_time_q  <= evt_time_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign filt_rst_n = !(state_q == S_IDLE || state_q == S_FLUSH);
   assign busy       = (state_q != S_IDLE);
   assign evt_valid  = evt_valid_q;
   assign evt_peak   = evt_peak_q;
   assign evt_time   = evt_time_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_v7_filter_ctrl.sv
// Directed bench for v7_filter_ctrl: event scoreboard checked at each transfer.
module tb_v7_filter_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_en;
   logic        flush_req;
   logic [15:0] cfg_threshold;
   logic [15:0] filt_data;
   logic        filt_rst_n;
   logic        evt_valid;
   logic        evt_ready;
   logic [15:0] evt_peak;
   logic [31:0] evt_time;
   logic [7:0]  drop_cnt;
   logic        busy;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] cyc = '0;
   logic [47:0] exp_q[$];
   logic [47:0] exp_item;
   logic [31:0] t_mark;

   v7_filter_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .cfg_en        (cfg_en),
      .flush_req     (flush_req),
      .cfg_threshold (cfg_threshold),
      .filt_data     (filt_data),
      .filt_rst_n    (filt_rst_n),
      .evt_valid     (evt_valid),
      .evt_ready     (evt_ready),
      .evt_peak      (evt_peak),
      .evt_time      (evt_time),
      .drop_cnt      (drop_cnt),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Reference cycle count: value the DUT timestamp holds while an input is presented.
   always @(posedge clk) begin
      if (!reset) cyc <= '0;
      else        cyc <= cyc + 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] d);
      filt_data = d;
      tick();
   endtask

   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) drive(16'd0);
   endtask

   // Pulse with a single peak sample, preceded by enough idle for dead time to lapse.
   task automatic pulse_emit(input logic [15:0] pk, input bit push);
      quiet(20);
      t_mark = cyc;
      drive(pk);
      if (push) exp_q.push_back({pk, t_mark});
      drive(16'd50);
   endtask

   // Scoreboard: a transfer happens on the next rising edge when both are high.
   always @(negedge clk) begin
      if (reset && evt_valid && evt_ready) begin
         n_tests++;
         assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL unexpected_evt got=%0h/%0h exp=none", evt_peak, evt_time);
         end
         if (exp_q.size() > 0) begin
            exp_item = exp_q.pop_front();
            n_tests++;
            assert ({evt_peak, evt_time} === exp_item) else begin
               n_fail++;
               $error("FAIL evt_data got=%0h exp=%0h", {evt_peak, evt_time}, exp_item);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; cfg_en = 1'b0; flush_req = 1'b0;
      cfg_threshold = 16'd100; filt_data = 16'd0; evt_ready = 1'b0;

      // Reset
      tick(); tick(); tick();
      check("rst_filt_rst_n", filt_rst_n, 0);
      check("rst_evt_valid", evt_valid, 0);
      check("rst_evt_peak", evt_peak, 0);
      check("rst_evt_time", evt_time, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_busy", busy, 0);
      reset = 1'b1;

      // Enable at ts=5 with a saturated filter output during flush/settle
      while (cyc != 32'd5) tick();
      cfg_en = 1'b1;
      drive(16'hFFFF);
      check("en_flush_rst0", filt_rst_n, 0);
      check("en_busy", busy, 1);
      drive(16'hFFFF);
      check("en_flush_rst1", filt_rst_n, 0);
      drive(16'hFFFF);
      check("en_rst_release", filt_rst_n, 1);
      for (int i = 0; i < 31; i++) drive(16'hFFFF);
      check("settle_no_evt", evt_valid, 0);

      // Single pulse; first ARMED sample is the 50
      drive(16'd50);
      drive(16'd120);
      t_mark = cyc;
      drive(16'd200);
      drive(16'd200);
      drive(16'd180);
      check("pulse_not_yet", evt_valid, 0);
      drive(16'd90);
      check("pulse_valid", evt_valid, 1);
      check("pulse_peak", evt_peak, 200);
      check("pulse_time", evt_time, t_mark);
      exp_q.push_back({16'd200, t_mark});
      evt_ready = 1'b1;
      drive(16'd0);
      evt_ready = 1'b0;
      check("pulse_accepted", evt_valid, 0);

      // Back-pressure: second event dropped
      pulse_emit(16'd300, 1'b1);
      pulse_emit(16'd400, 1'b0);
      check("bp_drop_cnt", drop_cnt, 1);
      check("bp_valid", evt_valid, 1);
      check("bp_peak_held", evt_peak, 300);
      evt_ready = 1'b1;
      drive(16'd0);
      evt_ready = 1'b0;
      check("bp_released", evt_valid, 0);

      // Accept and load on the same edge
      pulse_emit(16'd500, 1'b1);
      quiet(20);
      t_mark = cyc;
      drive(16'd600);
      exp_q.push_back({16'd600, t_mark});
      evt_ready = 1'b1;
      drive(16'd50);
      evt_ready = 1'b0;
      check("sim_valid", evt_valid, 1);
      check("sim_peak", evt_peak, 600);
      check("sim_drop_cnt", drop_cnt, 1);
      evt_ready = 1'b1;
      drive(16'd0);

      // Dead time: crossing 5 cycles after emit ignored, 17 cycles after captured
      pulse_emit(16'd650, 1'b1);
      quiet(4);
      drive(16'd700);
      quiet(11);
      t_mark = cyc;
      drive(16'd800);
      exp_q.push_back({16'd800, t_mark});
      drive(16'd50);
      quiet(2);
      check("dead_drop_cnt", drop_cnt, 1);
      check("dead_sb_empty", exp_q.size(), 0);
      evt_ready = 1'b0;

      // Abort: flush mid-PEAK, then disable mid-SETTLE, with an event pending
      pulse_emit(16'd900, 1'b1);
      quiet(20);
      drive(16'd1000);
      check("abort_pre_rst", filt_rst_n, 1);
      flush_req = 1'b1;
      drive(16'd1000);
      flush_req = 1'b0;
      check("abort_flush_rst", filt_rst_n, 0);
      check("abort_flush_busy", busy, 1);
      drive(16'd50);
      drive(16'd50);
      check("abort_settle_rst", filt_rst_n, 1);
      quiet(3);
      cfg_en = 1'b0;
      drive(16'd0);
      check("abort_idle_rst", filt_rst_n, 0);
      check("abort_idle_busy", busy, 0);
      check("abort_keep_valid", evt_valid, 1);
      check("abort_keep_peak", evt_peak, 900);
      check("abort_drop_cnt", drop_cnt, 1);
      evt_ready = 1'b1;
      drive(16'd0);
      evt_ready = 1'b0;
      check("abort_released", evt_valid, 0);
      quiet(2);
      check("final_sb_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
